// File: rtl/hacd_mc_rd_arb_pkg.sv
// Shared types and constants for the HACD -> MC read-channel arbiter.
package hacd_mc_rd_arb_pkg;

  localparam int unsigned HACD_RD_NUM_REQ   = 3;
  localparam int unsigned HACD_RD_REQ_CPU   = 0;
  localparam int unsigned HACD_RD_REQ_WALK  = 1;
  localparam int unsigned HACD_RD_REQ_CODEC = 2;

  localparam int unsigned HACD_RD_ADDR_W = 64;
  localparam int unsigned HACD_RD_LEN_W  = 8;
  localparam int unsigned HACD_RD_CNT_W  = 4;

  // One AR request payload as seen from a requester.
  typedef struct packed {
    logic [HACD_RD_ADDR_W-1:0] addr;
    logic [HACD_RD_LEN_W-1:0]  len;
  } hacd_rd_req_t;

endpackage

// File: rtl/hacd_mc_rd_arb_rr_arb.sv
// Parameterised round-robin arbiter: searches upward from an internal
// pointer with wrap; the pointer moves past the winner on an accepted grant.
module hacd_rr_arb #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     elig_i,
  input  logic             accept_i,
  output logic [N-1:0]     gnt_c_o,
  output logic [IDX_W-1:0] gnt_idx_c_o,
  output logic             gnt_vld_c_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  // First eligible index at or above the pointer, wrapping at N.
  always_comb begin
    gnt_c_o     = '0;
    gnt_idx_c_o = '0;
    gnt_vld_c_o = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % N);
      if (!gnt_vld_c_o && elig_i[cand]) begin
        gnt_vld_c_o   = 1'b1;
        gnt_idx_c_o   = cand;
        gnt_c_o[cand] = 1'b1;
      end
    end
  end

  // Pointer advance: winner+1 with wrap, only on an accepted grant.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && gnt_vld_c_o) begin
      ptr_d = (32'(gnt_idx_c_o) == N - 1) ? '0 : gnt_idx_c_o + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hacd_mc_rd_arb.sv
// Shares the single HACD->MC AXI read channel among NUM_REQ requesters:
// round-robin AR with a registered AR stage, ARID = requester index,
// RID-based R routing and per-requester outstanding-burst limits.
module hacd_mc_rd_arb
  import hacd_mc_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = HACD_RD_NUM_REQ,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = HACD_RD_ADDR_W,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_arvalid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_araddr_i,
  input  logic [NUM_REQ*8-1:0]        req_arlen_i,
  output logic [NUM_REQ-1:0]          req_arready_o,
  output logic [NUM_REQ-1:0]          req_rvalid_o,
  output logic [DATA_W-1:0]           req_rdata_o,
  output logic [1:0]                  req_rresp_o,
  output logic                        req_rlast_o,
  input  logic [NUM_REQ-1:0]          req_rready_i,
  output logic                        mc_arvalid_o,
  output logic [ADDR_W-1:0]           mc_araddr_o,
  output logic [7:0]                  mc_arlen_o,
  output logic [ID_W-1:0]             mc_arid_o,
  input  logic                        mc_arready_i,
  input  logic                        mc_rvalid_i,
  input  logic [ID_W-1:0]             mc_rid_i,
  input  logic [DATA_W-1:0]           mc_rdata_i,
  input  logic [1:0]                  mc_rresp_i,
  input  logic                        mc_rlast_i,
  output logic                        mc_rready_o,
  output logic [NUM_REQ*4-1:0]        outst_cnt_o,
  output logic                        rid_err_o
);

  localparam int unsigned CNT_W = HACD_RD_CNT_W;

  logic                 load_en;
  logic [NUM_REQ-1:0]   elig, gnt, inc, dec;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  hacd_rd_req_t         win_req;

  logic                 ar_vld_q, ar_vld_d;
  logic [ADDR_W-1:0]    ar_addr_q, ar_addr_d;
  logic [7:0]           ar_len_q, ar_len_d;
  logic [ID_W-1:0]      ar_id_q, ar_id_d;

  logic [CNT_W-1:0]     cnt_q [NUM_REQ];
  logic [CNT_W-1:0]     cnt_d [NUM_REQ];

  logic [IDX_W-1:0]     rid_idx;
  logic                 rid_ok;
  logic                 err_q, err_d;

  // The AR stage may take a new burst when empty or being drained.
  assign load_en = !ar_vld_q | mc_arready_i;

  // A requester competes only while below its outstanding limit.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_arvalid_i[i] & (32'(cnt_q[i]) < MAX_OUTST);
    end
  end

  hacd_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .elig_i      (elig),
    .accept_i    (load_en),
    .gnt_c_o     (gnt),
    .gnt_idx_c_o (gnt_idx),
    .gnt_vld_c_o (gnt_vld)
  );

  assign req_arready_o = load_en ? gnt : '0;
  assign inc           = req_arready_o;

  // Select the winner's payload through the one-hot grant.
  always_comb begin
    win_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_req.addr = HACD_RD_ADDR_W'(req_araddr_i[i*ADDR_W +: ADDR_W]);
        win_req.len  = req_arlen_i[i*8 +: 8];
      end
    end
  end

  // AR register next state: load on load_en, hold while stalled.
  always_comb begin
    ar_vld_d  = ar_vld_q;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    ar_id_d   = ar_id_q;
    if (load_en) begin
      ar_vld_d = gnt_vld;
      if (gnt_vld) begin
        ar_addr_d = ADDR_W'(win_req.addr);
        ar_len_d  = win_req.len;
        ar_id_d   = ID_W'(gnt_idx);
      end
    end
  end

  assign rid_idx = mc_rid_i[IDX_W-1:0];
  assign rid_ok  = ((mc_rid_i >> IDX_W) == '0) && (32'(rid_idx) < NUM_REQ);

  // Combinational R routing; beats with an unknown RID are sunk.
  always_comb begin
    req_rvalid_o = '0;
    mc_rready_o  = 1'b1;
    dec          = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rid_ok && 32'(rid_idx) == i) begin
        req_rvalid_o[i] = mc_rvalid_i;
        mc_rready_o     = req_rready_i[i];
        dec[i]          = mc_rvalid_i & req_rready_i[i] & mc_rlast_i;
      end
    end
  end

  // Outstanding counters: +1 at grant, -1 at last R beat, both cancel.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec[i] && !inc[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  assign err_d = err_q | (mc_rvalid_i & !rid_ok);

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_vld_q  <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_id_q   <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      ar_vld_q  <= ar_vld_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      ar_id_q   <= ar_id_d;
      err_q     <= err_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A last beat can never arrive for a requester with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        assert (!(dec[i] && cnt_q[i] == '0));
      end
    end
  end

  // Pack counters onto the status port.
  always_comb begin
    outst_cnt_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      outst_cnt_o[i*4 +: 4] = 4'(cnt_q[i]);
    end
  end

  assign mc_arvalid_o = ar_vld_q;
  assign mc_araddr_o  = ar_addr_q;
  assign mc_arlen_o   = ar_len_q;
  assign mc_arid_o    = ar_id_q;
  assign rid_err_o    = err_q;

  assign req_rdata_o  = mc_rdata_i;
  assign req_rresp_o  = mc_rresp_i;
  assign req_rlast_o  = mc_rlast_i;

endmodule

// File: tb/tb_hacd_mc_rd_arb.sv
// Bench for hacd_mc_rd_arb: directed cycle table followed by randomized
// traffic checked against a transaction-level reference model.
module tb_hacd_mc_rd_arb;
  import hacd_mc_rd_arb_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned MO = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_arvalid_i;
  logic [NR*AW-1:0]  req_araddr_i;
  logic [NR*8-1:0]   req_arlen_i;
  logic [NR-1:0]     req_arready_o;
  logic [NR-1:0]     req_rvalid_o;
  logic [DW-1:0]     req_rdata_o;
  logic [1:0]        req_rresp_o;
  logic              req_rlast_o;
  logic [NR-1:0]     req_rready_i;
  logic              mc_arvalid_o;
  logic [AW-1:0]     mc_araddr_o;
  logic [7:0]        mc_arlen_o;
  logic [3:0]        mc_arid_o;
  logic              mc_arready_i;
  logic              mc_rvalid_i;
  logic [3:0]        mc_rid_i;
  logic [DW-1:0]     mc_rdata_i;
  logic [1:0]        mc_rresp_i;
  logic              mc_rlast_i;
  logic              mc_rready_o;
  logic [NR*4-1:0]   outst_cnt_o;
  logic              rid_err_o;

  always #5 clk_i = ~clk_i;

  hacd_mc_rd_arb #(
    .NUM_REQ(NR), .IDX_W(2), .ID_W(4), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_arvalid_i(req_arvalid_i), .req_araddr_i(req_araddr_i),
    .req_arlen_i(req_arlen_i), .req_arready_o(req_arready_o),
    .req_rvalid_o(req_rvalid_o), .req_rdata_o(req_rdata_o),
    .req_rresp_o(req_rresp_o), .req_rlast_o(req_rlast_o),
    .req_rready_i(req_rready_i),
    .mc_arvalid_o(mc_arvalid_o), .mc_araddr_o(mc_araddr_o),
    .mc_arlen_o(mc_arlen_o), .mc_arid_o(mc_arid_o),
    .mc_arready_i(mc_arready_i),
    .mc_rvalid_i(mc_rvalid_i), .mc_rid_i(mc_rid_i), .mc_rdata_i(mc_rdata_i),
    .mc_rresp_i(mc_rresp_i), .mc_rlast_i(mc_rlast_i), .mc_rready_o(mc_rready_o),
    .outst_cnt_o(outst_cnt_o), .rid_err_o(rid_err_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] av;
    logic       arr;
    logic       rv;
    logic [3:0] rid;
    logic       rl;
    logic [2:0] rr;
    logic [2:0] e_ardy;
    logic       e_vld;
    logic [3:0] e_id;
    logic [2:0] e_rv;
    logic       e_mrr;
    logic [11:0] e_cnt;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(int rst, int av, int arr, int rv, int rid, int rl, int rr,
                              int e_ardy, int e_vld, int e_id, int e_rv, int e_mrr,
                              int e_cnt, int e_err);
    vec_t v;
    v.rst = 1'(rst); v.av = 3'(av); v.arr = 1'(arr); v.rv = 1'(rv);
    v.rid = 4'(rid); v.rl = 1'(rl); v.rr = 3'(rr);
    v.e_ardy = 3'(e_ardy); v.e_vld = 1'(e_vld); v.e_id = 4'(e_id);
    v.e_rv = 3'(e_rv); v.e_mrr = 1'(e_mrr); v.e_cnt = 12'(e_cnt); v.e_err = 1'(e_err);
    return v;
  endfunction

  vec_t        vq[$];
  logic [63:0] t_addr [NR];
  logic [7:0]  t_len  [NR];

  // Reference model state
  bit          m_vld;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  int          m_id;
  int          m_ptr;
  int          m_cnt [NR];
  bit          m_err;

  task automatic model_reset();
    m_vld = 0; m_addr = '0; m_len = '0; m_id = 0; m_ptr = 0; m_err = 0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
  endtask

  // Compare DUT against the model for the current inputs, then advance it.
  task automatic model_cycle(input int cyc);
    bit          load_en;
    int          win;
    int          rid;
    bit          rid_valid;
    logic [2:0]  e_ardy, e_rv;
    bit          e_mrr;
    logic [11:0] e_cnt;
    load_en = !m_vld || mc_arready_i;
    win = -1;
    if (load_en) begin
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (m_ptr + k) % NR;
        if (win < 0 && req_arvalid_i[c] && m_cnt[c] < MO) win = c;
      end
    end
    e_ardy = (win >= 0) ? 3'(1 << win) : 3'b000;
    rid = int'(mc_rid_i);
    rid_valid = rid < NR;
    e_rv  = (rid_valid && mc_rvalid_i) ? 3'(1 << rid) : 3'b000;
    e_mrr = rid_valid ? req_rready_i[rid] : 1'b1;
    e_cnt = {4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])};

    chk($sformatf("r%0d arready", cyc), 512'(req_arready_o), 512'(e_ardy));
    chk($sformatf("r%0d arvalid", cyc), 512'(mc_arvalid_o), 512'(m_vld));
    chk($sformatf("r%0d araddr", cyc), 512'(mc_araddr_o), 512'(m_addr));
    chk($sformatf("r%0d arlen", cyc), 512'(mc_arlen_o), 512'(m_len));
    chk($sformatf("r%0d arid", cyc), 512'(mc_arid_o), 512'(m_id));
    chk($sformatf("r%0d rvalid", cyc), 512'(req_rvalid_o), 512'(e_rv));
    chk($sformatf("r%0d rready", cyc), 512'(mc_rready_o), 512'(e_mrr));
    chk($sformatf("r%0d outst", cyc), 512'(outst_cnt_o), 512'(e_cnt));
    chk($sformatf("r%0d rid_err", cyc), 512'(rid_err_o), 512'(m_err));
    chk($sformatf("r%0d rdata", cyc), 512'(req_rdata_o),
        512'(mc_rdata_i));
    chk($sformatf("r%0d rresp_last", cyc), 512'({req_rresp_o, req_rlast_o}),
        512'({mc_rresp_i, mc_rlast_i}));

    if (load_en) begin
      if (win >= 0) begin
        m_vld = 1; m_id = win;
        m_addr = req_araddr_i[win*AW +: AW];
        m_len  = req_arlen_i[win*8 +: 8];
        m_cnt[win]++;
        m_ptr = (win + 1) % NR;
      end else begin
        m_vld = 0;
      end
    end
    if (mc_rvalid_i && rid_valid && e_mrr && mc_rlast_i) m_cnt[rid]--;
    if (mc_rvalid_i && !rid_valid) m_err = 1;
    if (rst_i) model_reset();
  endtask

  initial begin
    t_addr[HACD_RD_REQ_CPU]   = 64'hA000; t_len[HACD_RD_REQ_CPU]   = 8'd1;
    t_addr[HACD_RD_REQ_WALK]  = 64'h1000; t_len[HACD_RD_REQ_WALK]  = 8'd3;
    t_addr[HACD_RD_REQ_CODEC] = 64'h2000; t_len[HACD_RD_REQ_CODEC] = 8'd7;

    rst_i = 1'b1; req_arvalid_i = '0; mc_arready_i = 1'b0; mc_rvalid_i = 1'b0;
    mc_rid_i = '0; mc_rlast_i = 1'b0; req_rready_i = '1; mc_rresp_i = '0;
    mc_rdata_i = '0;
    req_araddr_i = {t_addr[2], t_addr[1], t_addr[0]};
    req_arlen_i  = {t_len[2], t_len[1], t_len[0]};

    // rst av arr rv rid rl rr | ardy vld id rv mrr cnt err
    vq.push_back(mk(0,0,1,0,0,0,7, 0,0,0,0,1,'h000,0)); // 0 reset state
    vq.push_back(mk(0,2,1,0,0,0,7, 2,0,0,0,1,'h000,0)); // 1 req1 issues
    vq.push_back(mk(0,0,1,0,0,0,7, 0,1,1,0,1,'h010,0)); // 2 mc_ar next cycle
    vq.push_back(mk(0,0,1,1,1,0,7, 0,0,0,2,1,'h010,0)); // 3 beats to req1
    vq.push_back(mk(0,0,1,1,1,0,7, 0,0,0,2,1,'h010,0));
    vq.push_back(mk(0,0,1,1,1,0,7, 0,0,0,2,1,'h010,0));
    vq.push_back(mk(0,0,1,1,1,1,7, 0,0,0,2,1,'h010,0)); // 6 rlast
    vq.push_back(mk(0,0,1,0,0,0,7, 0,0,0,0,1,'h000,0)); // 7 count back to 0
    vq.push_back(mk(0,7,1,0,0,0,7, 4,0,0,0,1,'h000,0)); // 8 fairness from ptr 2
    vq.push_back(mk(0,7,1,0,0,0,7, 1,1,2,0,1,'h100,0));
    vq.push_back(mk(0,7,1,0,0,0,7, 2,1,0,0,1,'h101,0));
    vq.push_back(mk(0,7,1,0,0,0,7, 4,1,1,0,1,'h111,0));
    vq.push_back(mk(0,7,1,0,0,0,7, 1,1,2,0,1,'h211,0));
    vq.push_back(mk(0,7,1,0,0,0,7, 2,1,0,0,1,'h212,0));
    for (int i = 0; i < 5; i++)                         // 14-18 backpressure
      vq.push_back(mk(0,7,0,0,0,0,7, 0,1,1,0,1,'h222,0));
    vq.push_back(mk(0,7,1,0,0,0,7, 4,1,1,0,1,'h222,0)); // 19 release, same-cycle grant
    vq.push_back(mk(0,1,1,0,0,0,7, 1,1,2,0,1,'h322,0)); // 20 req0 to limit
    vq.push_back(mk(0,1,1,0,0,0,7, 1,1,0,0,1,'h323,0));
    vq.push_back(mk(0,5,1,0,0,0,7, 4,1,0,0,1,'h324,0)); // 22 req0 blocked, req2 granted
    vq.push_back(mk(0,5,1,0,0,0,7, 0,1,2,0,1,'h424,0)); // 23 both at limit
    vq.push_back(mk(0,5,1,1,0,1,7, 0,0,0,1,1,'h424,0)); // 24 rlast rid0
    vq.push_back(mk(0,5,1,0,0,0,7, 1,0,0,0,1,'h423,0)); // 25 req0 granted next cycle
    vq.push_back(mk(0,0,1,1,2,1,7, 0,1,0,4,1,'h424,0)); // 26 rlast rid2
    vq.push_back(mk(0,4,1,1,2,1,7, 4,0,0,4,1,'h324,0)); // 27 grant + rlast on req2
    vq.push_back(mk(0,0,1,1,2,0,3, 0,1,2,4,0,'h324,0)); // 28 unchanged, R stall
    vq.push_back(mk(0,0,1,1,3,1,0, 0,0,0,0,1,'h324,0)); // 29 invalid rid 3
    vq.push_back(mk(0,0,1,1,9,0,0, 0,0,0,0,1,'h324,1)); // 30 invalid upper bits
    vq.push_back(mk(0,0,1,0,0,0,7, 0,0,0,0,1,'h324,1)); // 31 sticky
    vq.push_back(mk(1,4,1,0,0,0,7, 4,0,0,0,1,'h324,1)); // 32 reset mid-traffic
    vq.push_back(mk(0,0,1,0,0,0,7, 0,0,0,0,1,'h000,0)); // 33 all cleared
    vq.push_back(mk(0,7,1,0,0,0,7, 1,0,0,0,1,'h000,0)); // 34 pointer back to 0
    vq.push_back(mk(0,0,1,0,0,0,7, 0,1,0,0,1,'h001,0)); // 35

    repeat (2) @(posedge clk_i);

    for (int r = 0; r < vq.size(); r++) begin
      @(posedge clk_i); #1;
      rst_i         = vq[r].rst;
      req_arvalid_i = vq[r].av;
      mc_arready_i  = vq[r].arr;
      mc_rvalid_i   = vq[r].rv;
      mc_rid_i      = vq[r].rid;
      mc_rlast_i    = vq[r].rl;
      req_rready_i  = vq[r].rr;
      @(negedge clk_i);
      chk($sformatf("v%0d arready", r), 512'(req_arready_o), 512'(vq[r].e_ardy));
      chk($sformatf("v%0d arvalid", r), 512'(mc_arvalid_o), 512'(vq[r].e_vld));
      if (vq[r].e_vld) begin
        chk($sformatf("v%0d arid", r), 512'(mc_arid_o), 512'(vq[r].e_id));
        chk($sformatf("v%0d arlen", r), 512'(mc_arlen_o), 512'(t_len[vq[r].e_id]));
        chk($sformatf("v%0d araddr", r), 512'(mc_araddr_o), 512'(t_addr[vq[r].e_id]));
      end
      chk($sformatf("v%0d rvalid", r), 512'(req_rvalid_o), 512'(vq[r].e_rv));
      chk($sformatf("v%0d rready", r), 512'(mc_rready_o), 512'(vq[r].e_mrr));
      chk($sformatf("v%0d outst", r), 512'(outst_cnt_o), 512'(vq[r].e_cnt));
      chk($sformatf("v%0d rid_err", r), 512'(rid_err_o), 512'(vq[r].e_err));
    end

    // Randomized traffic against the reference model.
    @(posedge clk_i); #1;
    rst_i = 1'b1; req_arvalid_i = '0; mc_rvalid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int rid;
      #1;
      rst_i = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NR; i++) begin
        req_arvalid_i[i] = ($urandom_range(0, 99) < 60);
        req_araddr_i[i*AW +: AW] = {$urandom, $urandom};
        req_arlen_i[i*8 +: 8] = 8'($urandom_range(0, 255));
      end
      mc_arready_i = ($urandom_range(0, 99) < 65);
      mc_rvalid_i  = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 9) == 0) rid = $urandom_range(3, 15);
      else                           rid = $urandom_range(0, 2);
      mc_rid_i = 4'(rid);
      if (rid < NR) mc_rlast_i = (m_cnt[rid] > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      else          mc_rlast_i = 1'($urandom_range(0, 1));
      req_rready_i = 3'($urandom);
      for (int w = 0; w < DW / 32; w++) mc_rdata_i[w*32 +: 32] = $urandom;
      mc_rresp_i = 2'($urandom);
      @(negedge clk_i);
      model_cycle(cyc);
      @(posedge clk_i);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
